// File: rtl/writeback_stage_if.sv
// Writeback-stage bus: W pipeline register payload plus the two decode read ports.
interface writeback_stage_if #(
  parameter int unsigned XLEN = 64
);
  logic [3:0]      W_icode;
  logic [XLEN-1:0] W_valE;
  logic [XLEN-1:0] W_valM;
  logic [3:0]      W_dstE;
  logic [3:0]      W_dstM;
  logic [1:0]      W_stat;
  logic [3:0]      d_srcA;
  logic [3:0]      d_srcB;
  logic [XLEN-1:0] d_rvalA;
  logic [XLEN-1:0] d_rvalB;

  // Upstream side: memory stage drives W, decode drives read addresses.
  modport master (
    output W_icode, W_valE, W_valM, W_dstE, W_dstM, W_stat, d_srcA, d_srcB,
    input  d_rvalA, d_rvalB
  );

  // Writeback stage side.
  modport slave (
    input  W_icode, W_valE, W_valM, W_dstE, W_dstM, W_stat, d_srcA, d_srcB,
    output d_rvalA, d_rvalB
  );
endinterface

// File: rtl/writeback_stage.sv
// Y86-64 writeback stage: register file, status tracking, halt FSM, retire counter.
// Optional feature macro: WB_READ_BYPASS_EN (same-cycle write forwarding on read ports).
module writeback_stage #(
  parameter int unsigned     XLEN     = 64,
  parameter logic [3:0]      RNONE    = 4'hF,
  parameter logic [XLEN-1:0] RSP_INIT = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  writeback_stage_if.slave w,
  output logic [1:0]  Stat,
  output logic        halted,
  output logic [63:0] retire_count
);
  localparam int unsigned NREGS    = 15;
  localparam logic [3:0]  REG_RSP  = 4'd4;
  localparam logic [3:0]  ICODE_NOP = 4'h1;
  localparam logic [1:0]  STAT_AOK = 2'd0;
  localparam logic [1:0]  STAT_HLT = 2'd1;

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t          state;
  logic [XLEN-1:0] regs [NREGS];
  logic            wr_e_c;
  logic            wr_m_c;

  // A write is live only while running and retiring an AOK instruction.
  assign wr_e_c = (state == RUN) && (w.W_stat == STAT_AOK) && (w.W_dstE != RNONE);
  assign wr_m_c = (state == RUN) && (w.W_stat == STAT_AOK) && (w.W_dstM != RNONE);

  // Status FSM, register-file writes and saturating retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
      regs[REG_RSP] <= RSP_INIT;
      state         <= RUN;
      Stat          <= STAT_AOK;
      halted        <= 1'b0;
      retire_count  <= '0;
    end else begin
      case (state)
        RUN: begin
          case (w.W_stat)
            STAT_AOK: begin
              // valM assignment comes second so it wins on dstE==dstM.
              if (wr_e_c) regs[w.W_dstE] <= w.W_valE;
              if (wr_m_c) regs[w.W_dstM] <= w.W_valM;
              if (w.W_icode != ICODE_NOP && retire_count != '1) begin
                retire_count <= retire_count + 64'd1;
              end
            end
            STAT_HLT: begin
              if (retire_count != '1) retire_count <= retire_count + 64'd1;
              Stat   <= STAT_HLT;
              state  <= HALTED;
              halted <= 1'b1;
            end
            default: begin
              Stat   <= w.W_stat;
              state  <= HALTED;
              halted <= 1'b1;
            end
          endcase
        end
        default: begin
          state <= HALTED;
        end
      endcase
    end
  end

  // Read port A.
  always_comb begin
    w.d_rvalA = '0;
    if (w.d_srcA != RNONE) begin
`ifdef WB_READ_BYPASS_EN
      if (wr_m_c && w.d_srcA == w.W_dstM)      w.d_rvalA = w.W_valM;
      else if (wr_e_c && w.d_srcA == w.W_dstE) w.d_rvalA = w.W_valE;
      else                                     w.d_rvalA = regs[w.d_srcA];
`else
      w.d_rvalA = regs[w.d_srcA];
`endif
    end
  end

  // Read port B.
  always_comb begin
    w.d_rvalB = '0;
    if (w.d_srcB != RNONE) begin
`ifdef WB_READ_BYPASS_EN
      if (wr_m_c && w.d_srcB == w.W_dstM)      w.d_rvalB = w.W_valM;
      else if (wr_e_c && w.d_srcB == w.W_dstE) w.d_rvalB = w.W_valE;
      else                                     w.d_rvalB = regs[w.d_srcB];
`else
      w.d_rvalB = regs[w.d_srcB];
`endif
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage (RSP_INIT = 0x100).
module tb_writeback_stage;
  logic        clk;
  logic        rst_n;
  logic [1:0]  Stat;
  logic        halted;
  logic [63:0] retire_count;
  int          checks;
  int          errors;

  writeback_stage_if #(.XLEN(64)) wif ();

  writeback_stage #(
    .XLEN(64),
    .RNONE(4'hF),
    .RSP_INIT(64'h100)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .w(wif.slave),
    .Stat(Stat),
    .halted(halted),
    .retire_count(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] dste, input logic [63:0] vale,
                       input logic [3:0] dstm, input logic [63:0] valm, input logic [1:0] stat);
    wif.W_icode = icode;
    wif.W_dstE  = dste;
    wif.W_valE  = vale;
    wif.W_dstM  = dstm;
    wif.W_valM  = valm;
    wif.W_stat  = stat;
  endtask

  initial begin
    logic [63:0] byp_exp;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(4'h1, 4'hF, 64'd0, 4'hF, 64'd0, 2'd0);
    wif.d_srcA = 4'd4;
    wif.d_srcB = 4'd0;
    #12;
    rst_n = 1'b1;
    #1;

    // Reset state
    chk("rst_rsp", wif.d_rvalA, 64'h100);
    chk("rst_r0", wif.d_rvalB, 64'd0);
    chk("rst_stat", 64'(Stat), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_count", retire_count, 64'd0);

    // irmovq 55 -> r2
    drive(4'h3, 4'd2, 64'd55, 4'hF, 64'd0, 2'd0);
    wif.d_srcA = 4'd2;
    tick();
    chk("irmov_r2", wif.d_rvalA, 64'd55);
    chk("irmov_count", retire_count, 64'd1);

    // Bubble: not counted
    drive(4'h1, 4'hF, 64'd0, 4'hF, 64'd0, 2'd0);
    tick();
    chk("bubble_count", retire_count, 64'd1);

    // popq %rsp: valM wins
    drive(4'hB, 4'd4, 64'd40, 4'd4, 64'd99, 2'd0);
    wif.d_srcA = 4'd4;
    tick();
    chk("popq_rsp", wif.d_rvalA, 64'd99);
    chk("popq_count", retire_count, 64'd2);

    // dstE=4, dstM=0: independent writes
    drive(4'hB, 4'd4, 64'd40, 4'd0, 64'd99, 2'd0);
    wif.d_srcB = 4'd0;
    tick();
    chk("split_r4", wif.d_rvalA, 64'd40);
    chk("split_r0", wif.d_rvalB, 64'd99);
    chk("split_count", retire_count, 64'd3);

    // Same-cycle read of a register being written; RNONE reads 0
    drive(4'h3, 4'd6, 64'd123, 4'hF, 64'd0, 2'd0);
    wif.d_srcA = 4'd6;
    wif.d_srcB = 4'hF;
    #1;
`ifdef WB_READ_BYPASS_EN
    byp_exp = 64'd123;
`else
    byp_exp = 64'd0;
`endif
    chk("bypass_pre", wif.d_rvalA, byp_exp);
    chk("rnone_read", wif.d_rvalB, 64'd0);
    tick();
    chk("bypass_post", wif.d_rvalA, 64'd123);
    chk("bypass_count", retire_count, 64'd4);

    // ADR fault: write suppressed (and never forwarded)
    drive(4'h5, 4'hF, 64'd0, 4'd3, 64'd77, 2'd2);
    wif.d_srcA = 4'd3;
    #1;
    chk("adr_pre", wif.d_rvalA, 64'd0);
    tick();
    chk("adr_r3", wif.d_rvalA, 64'd0);
    chk("adr_stat", 64'(Stat), 64'd2);
    chk("adr_halted", 64'(halted), 64'd1);
    chk("adr_count", retire_count, 64'd4);

    // AOK after halt is ignored
    drive(4'h3, 4'd1, 64'd5, 4'hF, 64'd0, 2'd0);
    wif.d_srcA = 4'd1;
    tick();
    chk("halted_r1", wif.d_rvalA, 64'd0);
    chk("halted_stat", 64'(Stat), 64'd2);
    chk("halted_count", retire_count, 64'd4);

    // Reset, one write, then HLT
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    drive(4'h3, 4'd2, 64'd7, 4'hF, 64'd0, 2'd0);
    wif.d_srcA = 4'd2;
    wif.d_srcB = 4'd4;
    tick();
    chk("post_rst_r2", wif.d_rvalA, 64'd7);
    chk("post_rst_count", retire_count, 64'd1);
    drive(4'h0, 4'hF, 64'd0, 4'hF, 64'd0, 2'd1);
    tick();
    chk("hlt_stat", 64'(Stat), 64'd1);
    chk("hlt_halted", 64'(halted), 64'd1);
    chk("hlt_count", retire_count, 64'd2);

    // Mid-clock async reset takes effect without an edge
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_stat", 64'(Stat), 64'd0);
    chk("arst_halted", 64'(halted), 64'd0);
    chk("arst_count", retire_count, 64'd0);
    chk("arst_r2", wif.d_rvalA, 64'd0);
    chk("arst_rsp", wif.d_rvalB, 64'h100);
    #1;
    rst_n = 1'b1;

    // Running again after reset
    drive(4'h3, 4'd5, 64'd9, 4'hF, 64'd0, 2'd0);
    wif.d_srcA = 4'd5;
    tick();
    chk("rerun_r5", wif.d_rvalA, 64'd9);
    chk("rerun_count", retire_count, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final stage of the Y86-64 pipeline, directly downstream of the memory stage.
- Consumes the W pipeline register (W_icode, W_valE, W_valM, W_dstE, W_dstM, W_stat).
- Owns the 15-entry 64-bit architectural register file: writes valE/valM and serves two combinational read ports to decode.
- Tracks processor status: halts on the first non-AOK status, then freezes architectural state and counts retired instructions.

Parameters:
- XLEN, 64, data width of registers and values.
- RNONE, 4'hF, register ID meaning "no register"; never written, reads return 0.
- RSP_INIT, 64'd0, reset value of register 4 (%rsp); every other register resets to 0.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- W_icode  input  4  icode of instruction in writeback.
- W_valE  input  XLEN  ALU result.
- W_valM  input  XLEN  memory read data.
- W_dstE  input  4  destination for valE (RNONE = none).
- W_dstM  input  4  destination for valM (RNONE = none).
- W_stat  input  2  status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- d_srcA  input  4  decode read port A address.
- d_srcB  input  4  decode read port B address.
- d_rvalA  output  XLEN  register[d_srcA], 0 if RNONE.
- d_rvalB  output  XLEN  register[d_srcB], 0 if RNONE.
- Stat  output  2  processor status.
- halted  output  1  1 once a non-AOK status has retired; feeds W_stall and fetch-freeze control.
- retire_count  output  64  number of retired instructions.

Behaviour:
Reset (rst_n low, asynchronous, takes effect immediately):
- All registers 0, %rsp = RSP_INIT.
- Stat = 0, halted = 0, retire_count = 0, FSM in RUN.

FSM states:
- RUN:
  - W_stat==AOK: perform writes, increment retire_count if W_icode!=1 (nop/bubble not counted).
  - W_stat==HLT: no register writes, retire_count+1, Stat<=1, go HALTED.
  - W_stat==ADR or INS: suppress both writes, retire_count unchanged, Stat<=W_stat, go HALTED.
- HALTED:
  - Ignores all W_* inputs; no writes; retire_count frozen; Stat and halted hold.
  - Exit only via rst_n.
- halted = (state==HALTED), registered.
- Transition into HALTED takes effect at the edge on which the faulting or halting instruction is present; that same edge performs no write.

Register write rules (RUN, AOK, rising edge):
- regs[W_dstE] <= W_valE if W_dstE!=RNONE.
- regs[W_dstM] <= W_valM if W_dstM!=RNONE.
- If W_dstE==W_dstM!=RNONE: valM wins (popq %rsp semantics).
- Writes are independent of icode; the upstream stage guarantees dst = RNONE for non-writing or cancelled instructions.

Read ports:
- Purely combinational from the array; no write-to-read bypass (decode forwarding covers W) unless the optional feature is enabled.
- d_srcX==RNONE returns 0.

Counter:
- retire_count saturates at 2^64-1 and never wraps.

Reset mid-operation:
- Asserting rst_n low in RUN or HALTED immediately restores reset state; the write on any concurrent edge is lost.

Optional Feature:
- Macro WB_READ_BYPASS_EN.
- Defined: each read port forwards same-cycle write data when d_srcX matches an active write (valM priority over valE, then register array), so decode sees the value being written this cycle.
- Undefined: read ports return array contents only; a same-cycle write is visible on the cycle after the edge.

Test Plan:
- Reset with RSP_INIT=64'h100, then read d_srcA=4, d_srcB=0 -> d_rvalA=256, d_rvalB=0, Stat=0, halted=0, retire_count=0.
- irmovq retire: W_icode=3, W_dstE=2, W_valE=55, W_stat=0 -> after edge regs[2]=55, retire_count=1; W_icode=1 bubble next cycle -> count stays 1.
- popq %rsp: W_icode=11, W_dstE=4, W_valE=40, W_dstM=4, W_valM=99 -> regs[4]=99; with dstE=4, dstM=0 -> regs[4]=40, regs[0]=99.
- ADR fault: W_icode=5, W_dstM=3, W_valM=77, W_stat=2 -> regs[3] unchanged, Stat=2, halted=1, retire_count unchanged; following AOK write of 5 to reg 1 ignored.
- HLT: W_icode=0, W_stat=1 -> retire_count+1, Stat=1, halted=1; assert rst_n low mid-clock -> immediate Stat=0, halted=0, regs cleared without waiting for an edge.
- Bypass: write W_dstE=6, W_valE=123 while d_srcA=6 -> d_rvalA=123 before the edge with WB_READ_BYPASS_EN defined, old value without it.
